// File: rtl/ir_carrier_pkg.sv
// Shared types and default-derivation helpers for the IR carrier generator.
package ir_carrier_pkg;

  // Carrier FSM: IDLE (output low) or RUN (periods being generated).
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Period in clocks minus one for the requested carrier frequency.
  function automatic int unsigned def_period(input int unsigned clk_hz,
                                             input int unsigned carrier_hz);
    return (clk_hz / carrier_hz) - 1;
  endfunction

  // Nominal 50% duty high time for the requested carrier frequency.
  function automatic int unsigned def_high(input int unsigned clk_hz,
                                           input int unsigned carrier_hz);
    return (def_period(clk_hz, carrier_hz) + 1) / 2;
  endfunction

endpackage

// File: rtl/ir_carrier_cfg_shadow.sv
// Shadow/active configuration registers for the IR carrier generator.
// Incoming config is clamped on capture, held in a shadow until the FSM
// signals a period boundary, then copied into the active registers.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   cfg_period_i       requested period (clocks-1)
//   cfg_high_i         requested high time (clocks)
//   cfg_load_i         capture strobe
//   apply_i            boundary strobe from the FSM (applies only if pending)
//   period_act_o       active period
//   high_act_o         active high time
//   high_next_c        high time in effect for a period starting this edge
//   cfg_pending_o      shadow captured, not yet applied
module ir_carrier_cfg_shadow
  import ir_carrier_pkg::*;
#(
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned DEF_PERIOD = 1314,
  parameter int unsigned DEF_HIGH   = 657
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic [CNT_W-1:0] cfg_high_i,
  input  logic             cfg_load_i,
  input  logic             apply_i,
  output logic [CNT_W-1:0] period_act_o,
  output logic [CNT_W-1:0] high_act_o,
  output logic [CNT_W-1:0] high_next_c,
  output logic             cfg_pending_o
);

  localparam int unsigned W1 = CNT_W + 1;

  logic [CNT_W-1:0] sh_period_q, sh_period_d;
  logic [CNT_W-1:0] sh_high_q, sh_high_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic             pending_q, pending_d;

  logic [CNT_W-1:0] per_clamp;
  logic [W1-1:0]    per_plus1;
  logic [CNT_W-1:0] high_clamp;
  logic             do_apply;

  // Clamp: period >= 1 (2-clock minimum), high <= period+1 (100% duty).
  // period+1 is formed one bit wider so a full-scale period cannot wrap.
  always_comb begin
    per_clamp  = (cfg_period_i == '0) ? CNT_W'(1) : cfg_period_i;
    per_plus1  = {1'b0, per_clamp} + W1'(1);
    high_clamp = cfg_high_i;
    if ({1'b0, cfg_high_i} > per_plus1) begin
      high_clamp = CNT_W'(per_plus1);
    end
  end

  assign do_apply    = apply_i & pending_q;
  assign high_next_c = do_apply ? sh_high_q : act_high_q;

  // Apply uses the old shadow; a simultaneous load becomes the new pending value.
  always_comb begin
    sh_period_d  = sh_period_q;
    sh_high_d    = sh_high_q;
    act_period_d = act_period_q;
    act_high_d   = act_high_q;
    pending_d    = pending_q;
    if (do_apply) begin
      act_period_d = sh_period_q;
      act_high_d   = sh_high_q;
      pending_d    = 1'b0;
    end
    if (cfg_load_i) begin
      sh_period_d = per_clamp;
      sh_high_d   = high_clamp;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_period_q  <= CNT_W'(DEF_PERIOD);
      sh_high_q    <= CNT_W'(DEF_HIGH);
      act_period_q <= CNT_W'(DEF_PERIOD);
      act_high_q   <= CNT_W'(DEF_HIGH);
      pending_q    <= 1'b0;
    end else begin
      sh_period_q  <= sh_period_d;
      sh_high_q    <= sh_high_d;
      act_period_q <= act_period_d;
      act_high_q   <= act_high_d;
      pending_q    <= pending_d;
    end
  end

  assign period_act_o  = act_period_q;
  assign high_act_o    = act_high_q;
  assign cfg_pending_o = pending_q;

endmodule

// File: rtl/ir_carrier_gen.sv
// Programmable IR carrier generator with glitch-free start/stop and
// whole-period mark/space gating. Config changes take effect at period
// boundaries only.
// Ports:
//   CLK_50M, reset_n   clock, async active-low reset
//   cfg_period/high    requested period (clocks-1) / high time (clocks)
//   cfg_load           capture strobe for cfg_*
//   cfg_pending        captured config not yet applied
//   carrier_en         level request to run
//   mod_in             mark(1)/space(0) gate, sampled at period starts
//   carrier_out        registered carrier
//   period_tick        first clock of each running period
//   running            FSM in RUN
module ir_carrier_gen
  import ir_carrier_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned CARRIER_HZ = 38_000,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned DEF_PERIOD = def_period(CLK_HZ, CARRIER_HZ),
  parameter int unsigned DEF_HIGH   = def_high(CLK_HZ, CARRIER_HZ)
) (
  input  logic             CLK_50M,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             cfg_load,
  output logic             cfg_pending,
  input  logic             carrier_en,
  input  logic             mod_in,
  output logic             carrier_out,
  output logic             period_tick,
  output logic             running
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mark_q, mark_d;
  logic             car_q, car_d;
  logic             tick_q, tick_d;
  logic             run_q, run_d;
  logic             apply_c;

  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] high_act;
  logic [CNT_W-1:0] high_next_c;

  ir_carrier_cfg_shadow #(
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_HIGH   (DEF_HIGH)
  ) u_cfg (
    .clk_i         (CLK_50M),
    .rst_ni        (reset_n),
    .cfg_period_i  (cfg_period),
    .cfg_high_i    (cfg_high),
    .cfg_load_i    (cfg_load),
    .apply_i       (apply_c),
    .period_act_o  (period_act),
    .high_act_o    (high_act),
    .high_next_c   (high_next_c),
    .cfg_pending_o (cfg_pending)
  );

  // Next-state / output logic. Outputs are computed for the counter value
  // that will be held after this edge, so carrier_out lines up with cnt_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mark_d  = mark_q;
    car_d   = 1'b0;
    apply_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (carrier_en) begin
          state_d = RUN;
          cnt_d   = '0;
          mark_d  = mod_in;
          apply_c = 1'b1;
          car_d   = (high_next_c != '0) & mod_in;
        end
      end
      RUN: begin
        if (cnt_q == period_act) begin
          // Boundary: resample gate, apply pending config, maybe stop.
          cnt_d   = '0;
          mark_d  = mod_in;
          apply_c = 1'b1;
          if (!carrier_en) begin
            state_d = IDLE;
          end else begin
            car_d = (high_next_c != '0) & mod_in;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          car_d = (cnt_d < high_act) & mark_q;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d  = (state_d == RUN);
    tick_d = (state_d == RUN) && (cnt_d == '0);
  end

  always_ff @(posedge CLK_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mark_q  <= 1'b0;
      car_q   <= 1'b0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mark_q  <= mark_d;
      car_q   <= car_d;
      tick_q  <= tick_d;
      run_q   <= run_d;
    end
  end

  assign carrier_out = car_q;
  assign period_tick = tick_q;
  assign running     = run_q;

endmodule
